alu_flag_ctrl: RTL and testbench



---
 rtl/alu_flag_ctrl.sv | 112 +++++++++++
 tb/tb_alu_flag_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_ctrl.sv
// alu_flag_ctrl: architectural {Z,V,N} flag register for the pipelined core.
// Decides per EX opcode which flag bits the ALU may update, forwards in-flight
// EX flags to the ID-stage branch resolver, evaluates the branch condition and
// tracks the sticky halt state.
module alu_flag_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  logic [3:0] ex_opcode,
    input  logic [2:0] alu_flags,
    input  logic       stall_ex,
    input  logic       flush_ex,
    input  logic       br_valid,
    input  logic [2:0] br_cond,
    output logic [2:0] flags_q,
    output logic       br_taken,
    output logic       halted
);

    // Flag vectors are packed {Z,V,N}.
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        CC_NE = 3'b000,
        CC_EQ = 3'b001,
        CC_GT = 3'b010,
        CC_LT = 3'b011,
        CC_GE = 3'b100,
        CC_LE = 3'b101,
        CC_OV = 3'b110,
        CC_UN = 3'b111
    } cond_e;

    logic [2:0] mask;
    logic       commit;
    logic       fwd_en;
    logic [2:0] eff;
    logic       cond_met;

    // Which flag bits the EX opcode is allowed to write.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        mask = 3'b000;
        unique case (opcode_e'(ex_opcode))
            OP_ADD, OP_SUB:                 mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b100;
            default:                        mask = 3'b000;
        endcase
    end

    // A squashed, stalled or post-halt instruction never reaches the register.
    assign commit = ex_valid & ~stall_ex & ~flush_ex & ~halted;

    // Forwarding ignores the stall: the held EX instruction still precedes ID.
    assign fwd_en = ex_valid & ~flush_ex & ~halted;

    // Per bit, take the in-flight ALU flag where it will eventually be written.
    assign eff = ({3{fwd_en}} & mask & alu_flags) | (~({3{fwd_en}} & mask) & flags_q);

    // Branch condition on the effective flags.
    always_comb begin
        cond_met = 1'b0;
        unique case (cond_e'(br_cond))
            CC_NE: cond_met = ~eff[FLAG_Z];
            CC_EQ: cond_met =  eff[FLAG_Z];
            CC_GT: cond_met = ~eff[FLAG_Z] & ~eff[FLAG_N];
            CC_LT: cond_met =  eff[FLAG_N];
            CC_GE: cond_met =  eff[FLAG_Z] | (~eff[FLAG_Z] & ~eff[FLAG_N]);
            CC_LE: cond_met =  eff[FLAG_N] | eff[FLAG_Z];
            CC_OV: cond_met =  eff[FLAG_V];
            CC_UN: cond_met =  1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    assign br_taken = br_valid & cond_met;

    // Flag register and sticky halt; reset wins over everything.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            flags_q <= 3'b000;
            halted  <= 1'b0;
        end else if (commit) begin
            flags_q <= (flags_q & ~mask) | (alu_flags & mask);
            if (opcode_e'(ex_opcode) == OP_HLT)
                halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_flag_ctrl.sv
// tb_alu_flag_ctrl: directed, scoreboard-based bench for alu_flag_ctrl.
// Expected {halted, br_taken, flags_q} words are pushed as each step is driven
// and popped against the DUT outputs shortly after the inputs settle.
module tb_alu_flag_ctrl;

    logic       clk;
    logic       rst;
    logic       ex_valid;
    logic [3:0] ex_opcode;
    logic [2:0] alu_flags;
    logic       stall_ex;
    logic       flush_ex;
    logic       br_valid;
    logic [2:0] br_cond;
    logic [2:0] flags_q;
    logic       br_taken;
    logic       halted;

    int total = 0;
    int bad   = 0;

    string      tag_q[$];
    logic [4:0] exp_q[$];

    // Reference state tracked alongside the DUT.
    logic [2:0] m_flags;
    logic       m_halted;

    alu_flag_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (ex_valid),
        .ex_opcode(ex_opcode),
        .alu_flags(alu_flags),
        .stall_ex (stall_ex),
        .flush_ex (flush_ex),
        .br_valid (br_valid),
        .br_cond  (br_cond),
        .flags_q  (flags_q),
        .br_taken (br_taken),
        .halted   (halted)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2:0] m_mask(input logic [3:0] op);
        if (op == 4'h0 || op == 4'h1) return 3'b111;
        if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic m_taken();
        logic [2:0] e;
        logic [2:0] mk;
        logic z, v, n, c;
        mk = m_mask(ex_opcode);
        for (int i = 0; i < 3; i++)
            e[i] = (ex_valid && !flush_ex && !m_halted && mk[i]) ? alu_flags[i] : m_flags[i];
        z = e[2]; v = e[1]; n = e[0];
        case (br_cond)
            3'd0: c = !z;
            3'd1: c = z;
            3'd2: c = !z && !n;
            3'd3: c = n;
            3'd4: c = z || !n;
            3'd5: c = n || z;
            3'd6: c = v;
            default: c = 1'b1;
        endcase
        return br_valid && c;
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] af,
                         input logic st, input logic fl, input logic bv,
                         input logic [2:0] bc, input logic r);
        ex_valid  = v;
        ex_opcode = op;
        alu_flags = af;
        stall_ex  = st;
        flush_ex  = fl;
        br_valid  = bv;
        br_cond   = bc;
        rst       = r;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    // Push expectation from the reference model.
    task automatic push_model(input string tag);
        tag_q.push_back(tag);
        exp_q.push_back({m_halted, m_taken(), m_flags});
    endtask

    // Push a hand-derived expectation.
    task automatic push_const(input string tag, input logic [2:0] f, input logic t, input logic h);
        tag_q.push_back(tag);
        exp_q.push_back({h, t, f});
    endtask

    // Let inputs settle, then drain the scoreboard against the DUT.
    task automatic check();
        logic [4:0] obs;
        logic [4:0] exp;
        string      tag;
        #1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            obs = {halted, br_taken, flags_q};
            total++;
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s: observed {halted,taken,flags}=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    // Advance the model with the current inputs, then cross one rising edge.
    task automatic edge_step();
        logic [2:0] mk;
        mk = m_mask(ex_opcode);
        if (rst) begin
            m_flags  = 3'b000;
            m_halted = 1'b0;
        end else if (ex_valid && !stall_ex && !flush_ex && !m_halted) begin
            m_flags = (m_flags & ~mk) | (alu_flags & mk);
            if (ex_opcode == 4'hF) m_halted = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] effs [4];
        logic [7:0] tbl  [4];
        effs[0] = 3'b000; tbl[0] = 8'b10010101;
        effs[1] = 3'b001; tbl[1] = 8'b10101001;
        effs[2] = 3'b010; tbl[2] = 8'b11010101;
        effs[3] = 3'b100; tbl[3] = 8'b10110010;
        m_flags  = 3'b000;
        m_halted = 1'b0;

        // Reset with garbage on the inputs: rst must dominate.
        drive(1'b1, 4'h0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        @(negedge clk);
        edge_step();
        edge_step();
        idle();
        push_const("reset", 3'b000, 1'b0, 1'b0);
        check();

        // ADD then XOR commits.
        drive(1'b1, 4'h0, 3'b011, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        push_model("add_in_ex");
        check();
        edge_step();
        drive(1'b1, 4'h2, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        push_const("add_commit", 3'b011, 1'b0, 1'b0);
        check();
        edge_step();
        idle();
        push_const("xor_commit", 3'b111, 1'b0, 1'b0);
        check();

        // Non-flag opcodes leave a cleared register alone.
        drive(1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        edge_step();
        drive(1'b1, 4'h3, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        edge_step();
        drive(1'b1, 4'h7, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        edge_step();
        drive(1'b1, 4'h8, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        edge_step();
        idle();
        push_const("no_write_ops", 3'b000, 1'b0, 1'b0);
        check();

        // Forwarded SUB Z satisfies EQ; a flush kills the forward and the commit.
        drive(1'b1, 4'h1, 3'b100, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0);
        push_const("fwd_eq", 3'b000, 1'b1, 1'b0);
        check();
        drive(1'b1, 4'h1, 3'b100, 1'b1, 1'b1, 1'b1, 3'b001, 1'b0);
        push_const("flush_fwd", 3'b000, 1'b0, 1'b0);
        check();
        edge_step();
        drive(1'b1, 4'h1, 3'b100, 1'b0, 1'b1, 1'b1, 3'b001, 1'b0);
        push_const("flush_no_fwd", 3'b000, 1'b0, 1'b0);
        check();
        edge_step();
        idle();
        push_const("flush_no_commit", 3'b000, 1'b0, 1'b0);
        check();

        // Three stalled cycles of ADD: register holds, LT sees forwarded N.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h0, 3'b001, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0);
            push_const($sformatf("stall_%0d", i), 3'b000, 1'b1, 1'b0);
            check();
            edge_step();
        end
        drive(1'b1, 4'h0, 3'b001, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0);
        push_const("stall_release", 3'b000, 1'b1, 1'b0);
        check();
        edge_step();
        idle();
        push_const("stall_commit", 3'b001, 1'b0, 1'b0);
        check();

        // Condition sweep on forwarded flags; stall keeps the register at 001.
        for (int e = 0; e < 4; e++) begin
            for (int c = 0; c < 8; c++) begin
                drive(1'b1, 4'h0, effs[e], 1'b1, 1'b0, 1'b1, 3'(c), 1'b0);
                push_const($sformatf("cc%0d_eff%b", c, effs[e]), 3'b001, tbl[e][c], 1'b0);
                push_model($sformatf("model_cc%0d_eff%b", c, effs[e]));
                check();
            end
        end
        drive(1'b1, 4'h0, 3'b100, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0);
        push_const("br_valid_low", 3'b001, 1'b0, 1'b0);
        check();
        edge_step();

        // HLT commit, then the register and forwarding freeze.
        drive(1'b1, 4'hF, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        push_const("hlt_in_ex", 3'b001, 1'b0, 1'b0);
        check();
        edge_step();
        drive(1'b1, 4'h0, 3'b111, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
        push_const("halted_no_fwd", 3'b001, 1'b0, 1'b1);
        check();
        edge_step();
        drive(1'b1, 4'h0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        push_const("halted_frozen", 3'b001, 1'b0, 1'b1);
        check();
        edge_step();
        idle();
        push_const("reset_from_halt", 3'b000, 1'b0, 1'b0);
        push_model("model_after_reset");
        check();

        // Reset in the middle of a stall.
        drive(1'b1, 4'h0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        edge_step();
        drive(1'b1, 4'h2, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
        push_const("pre_reset_stall", 3'b111, 1'b0, 1'b0);
        check();
        edge_step();
        idle();
        push_const("reset_mid_stall", 3'b000, 1'b0, 1'b0);
        check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
